fsm_in: RTL and testbench
=========================

FSM_IN -- requirements
Module: fsm_in

Interface
REQ-001 Parameter W_WIDTH, default 8, SHALL set the byte width of data, address and FIFO paths.
REQ-002 Parameter N_PORTS, default 4, SHALL set the number of output ports and FIFOs.
REQ-003 Port clk, input, 1: single clock; all logic on rising edge.
REQ-004 Port rst_n, input, 1: reset is synchronous and active-high; asserted when rst_n=1.
REQ-005 Port sw_enable_in, input, 1: frames a packet; high for every valid byte of one packet.
REQ-006 Port data_in, input, W_WIDTH: packet byte, sampled when sw_enable_in=1.
REQ-007 Port port_addr, input, N_PORTS*W_WIDTH: port i address at slice [i*W_WIDTH +: W_WIDTH]; static during a packet.
REQ-008 Port fifo_full, input, N_PORTS: bit i high = port i FIFO cannot accept a write.
REQ-009 Port wr_en, output, N_PORTS: write strobe per port FIFO.
REQ-010 Port fifo_data, output, W_WIDTH: byte written to every FIFO strobed by wr_en.
REQ-011 Port busy, output, 1: high from first accepted byte until return to IDLE.
REQ-012 Port pkt_done, pkt_drop, err_len, output, 1 each: single-cycle status pulses.

Function
REQ-013 Packet format SHALL be DA, SA, LEN, then LEN payload bytes; LEN=0 is legal (3-byte packet).
REQ-014 States SHALL be IDLE, SA, LEN, PAYLOAD, WAIT_LOW, DROP.
REQ-015 In IDLE with sw_enable_in=1, data_in is DA; match mask bit i = (DA == port_addr slice i); multiple bits may be set (multicast).
REQ-016 If mask is zero, or (mask & fifo_full) is nonzero at DA, the packet SHALL go to DROP, write nothing, and pulse pkt_drop the next cycle.
REQ-017 Otherwise mask SHALL be latched and the FSM SHALL go IDLE->SA->LEN->PAYLOAD, advancing one state per accepted byte.
REQ-018 Every accepted byte (DA, SA, LEN, payload) SHALL appear on fifo_data with wr_en=latched mask exactly one cycle after sampling; registered outputs.
REQ-019 In LEN, data_in SHALL load an W_WIDTH-bit down-counter; if LEN=0, the FSM SHALL go directly to WAIT_LOW and pulse pkt_done.
REQ-020 In PAYLOAD, each byte SHALL decrement the counter; the byte that brings it to 0 is the last, after which pkt_done pulses with that byte's write and the FSM goes to WAIT_LOW.
REQ-021 In WAIT_LOW and DROP, bytes SHALL be ignored (wr_en=0) until sw_enable_in=0, then the FSM SHALL go to IDLE.
REQ-022 sw_enable_in falling in SA, LEN or PAYLOAD before the count completes SHALL pulse err_len, stop writes, and return the FSM to IDLE.
REQ-023 A matched FIFO becoming full mid-packet SHALL suppress only that port's wr_en bit for that byte; no other effect.
REQ-024 A new packet SHALL require at least one cycle of sw_enable_in=0; no back-to-back packets without a gap.
REQ-025 wr_en and fifo_data SHALL be 0 in any cycle with no write.

Reset
REQ-026 With rst_n=1 at a clock edge, state=IDLE, counter=0, mask=0, and wr_en, fifo_data, busy, pkt_done, pkt_drop, err_len SHALL be 0 on the following cycle.
REQ-027 Reset mid-packet SHALL abandon the packet with no pulse; remaining bytes while sw_enable_in stays high after reset release SHALL be treated as a new DA.

Structure
REQ-028 A shared package switch_pkg SHALL hold W_WIDTH and N_PORTS defaults, the state enum, and the packet header offsets (DA=0, SA=1, LEN=2).
REQ-029 One combinational sub-module, addr_match, SHALL compute the N_PORTS match mask from DA and port_addr.
REQ-030 The implementation SHALL be 120-400 lines of RTL, excluding the package.

Verification
REQ-031 Port addrs 0x11,0x22,0x33,0x44; send DA=0x22,SA=0x05,LEN=2,0xAA,0xBB -> wr_en=4'b0010 for 5 consecutive cycles with bytes in order; pkt_done on the 0xBB write.
REQ-032 Addrs 0x11,0x22,0x22,0x44; DA=0x22, LEN=0 -> wr_en=4'b0110 for 3 bytes; pkt_done on the LEN write.
REQ-033 DA=0x99 (no match), or DA=0x11 with fifo_full=4'b0001 -> no wr_en, pkt_drop one cycle after DA, IDLE after sw_enable_in=0.
REQ-034 DA=0x33, LEN=5, sw_enable_in drops after 2 payload bytes -> 5 writes, err_len pulse, no pkt_done, busy=0.
REQ-035 LEN=1 with 3 extra bytes held high -> 4 writes, then 3 ignored bytes, IDLE after sw_enable_in=0.
REQ-036 rst_n=1 during PAYLOAD -> all outputs 0 next cycle, no status pulse; the next packet after the gap forwards correctly.

Source files
------------

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared widths, FSM states and header offsets for the packet switch input
package switch_pkg;

    localparam int DEF_W_WIDTH = 8;
    localparam int DEF_N_PORTS = 4;

    localparam int HDR_DA  = 0;
    localparam int HDR_SA  = 1;
    localparam int HDR_LEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SA,
        ST_LEN,
        ST_PAYLOAD,
        ST_WAIT_LOW,
        ST_DROP
    } state_t;

endpackage

// File: rtl/addr_match.sv
// rtl/addr_match.sv - destination address compare against every port address
module addr_match
    import switch_pkg::*;
#(
    parameter int W_WIDTH = DEF_W_WIDTH,
    parameter int N_PORTS = DEF_N_PORTS
) (
    input  logic [W_WIDTH-1:0]         da,
    input  logic [N_PORTS*W_WIDTH-1:0] port_addr,
    output logic [N_PORTS-1:0]         mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            mask[i] = (da == port_addr[i*W_WIDTH +: W_WIDTH]);
        end
    end

endmodule

// File: rtl/fsm_in.sv
// rtl/fsm_in.sv - input-side packet parser that forwards DA/SA/LEN/payload bytes to matched port FIFOs
module fsm_in
    import switch_pkg::*;
#(
    parameter int W_WIDTH = DEF_W_WIDTH,
    parameter int N_PORTS = DEF_N_PORTS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sw_enable_in,
    input  logic [W_WIDTH-1:0]         data_in,
    input  logic [N_PORTS*W_WIDTH-1:0] port_addr,
    input  logic [N_PORTS-1:0]         fifo_full,
    output logic [N_PORTS-1:0]         wr_en,
    output logic [W_WIDTH-1:0]         fifo_data,
    output logic                       busy,
    output logic                       pkt_done,
    output logic                       pkt_drop,
    output logic                       err_len
);

    state_t               state, state_nx;
    logic [W_WIDTH-1:0]   cnt, cnt_nx;
    logic [N_PORTS-1:0]   dst_mask, dst_mask_nx;
    logic [N_PORTS-1:0]   match_mask;
    logic [N_PORTS-1:0]   wr_base;
    logic [N_PORTS-1:0]   wr_nx;
    logic [W_WIDTH-1:0]   data_nx;
    logic                 take;
    logic                 done_nx, drop_nx, err_nx;

    addr_match #(
        .W_WIDTH(W_WIDTH),
        .N_PORTS(N_PORTS)
    ) u_addr_match (
        .da       (data_in),
        .port_addr(port_addr),
        .mask     (match_mask)
    );

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        dst_mask_nx = dst_mask;
        wr_base     = dst_mask;
        take        = 1'b0;
        done_nx     = 1'b0;
        drop_nx     = 1'b0;
        err_nx      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sw_enable_in) begin
                    if ((match_mask == '0) || ((match_mask & fifo_full) != '0)) begin
                        state_nx = ST_DROP;
                        drop_nx  = 1'b1;
                    end else begin
                        // DA write uses the live match since the mask latches this same edge
                        dst_mask_nx = match_mask;
                        wr_base     = match_mask;
                        take        = 1'b1;
                        state_nx    = ST_SA;
                    end
                end
            end
            ST_SA, ST_LEN, ST_PAYLOAD: begin
                if (!sw_enable_in) begin
                    err_nx      = 1'b1;
                    dst_mask_nx = '0;
                    state_nx    = ST_IDLE;
                end else begin
                    take = 1'b1;
                    if (state == ST_SA) begin
                        state_nx = ST_LEN;
                    end else if (state == ST_LEN) begin
                        cnt_nx = data_in;
                        if (data_in == '0) begin
                            done_nx  = 1'b1;
                            state_nx = ST_WAIT_LOW;
                        end else begin
                            state_nx = ST_PAYLOAD;
                        end
                    end else begin
                        cnt_nx = cnt - W_WIDTH'(1);
                        if (cnt == W_WIDTH'(1)) begin
                            done_nx  = 1'b1;
                            state_nx = ST_WAIT_LOW;
                        end
                    end
                end
            end
            ST_WAIT_LOW, ST_DROP: begin
                if (!sw_enable_in) begin
                    dst_mask_nx = '0;
                    state_nx    = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        wr_nx   = take ? (wr_base & ~fifo_full) : '0;
        data_nx = (wr_nx != '0) ? data_in : '0;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dst_mask  <= '0;
            wr_en     <= '0;
            fifo_data <= '0;
            pkt_done  <= 1'b0;
            pkt_drop  <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            dst_mask  <= dst_mask_nx;
            wr_en     <= wr_nx;
            fifo_data <= data_nx;
            pkt_done  <= done_nx;
            pkt_drop  <= drop_nx;
            err_len   <= err_nx;
        end
    end

    assign busy = (state == ST_SA) || (state == ST_LEN) ||
                  (state == ST_PAYLOAD) || (state == ST_WAIT_LOW);

endmodule

// File: tb/tb_fsm_in.sv
// tb/tb_fsm_in.sv - scoreboard bench for fsm_in
module tb_fsm_in;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sw_enable_in = 1'b0;
    logic [7:0]  data_in = '0;
    logic [31:0] port_addr = {8'h44, 8'h33, 8'h22, 8'h11};
    logic [3:0]  fifo_full = '0;
    logic [3:0]  wr_en;
    logic [7:0]  fifo_data;
    logic        busy, pkt_done, pkt_drop, err_len;

    typedef struct packed {
        logic [3:0] wr;
        logic [7:0] data;
        logic       done;
        logic       drop;
        logic       err;
        logic       busy;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    fsm_in #(.W_WIDTH(8), .N_PORTS(4)) dut (
        .clk         (clk),
        .rst_n       (rst),
        .sw_enable_in(sw_enable_in),
        .data_in     (data_in),
        .port_addr   (port_addr),
        .fifo_full   (fifo_full),
        .wr_en       (wr_en),
        .fifo_data   (fifo_data),
        .busy        (busy),
        .pkt_done    (pkt_done),
        .pkt_drop    (pkt_drop),
        .err_len     (err_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        exp_t  e;
        exp_t  got;
        string t;
        #2;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            t   = tag_q.pop_front();
            got = {wr_en, fifo_data, pkt_done, pkt_drop, err_len, busy};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s: got wr=%b data=%h done=%b drop=%b err=%b busy=%b, expected wr=%b data=%h done=%b drop=%b err=%b busy=%b",
                         t, got.wr, got.data, got.done, got.drop, got.err, got.busy,
                         e.wr, e.data, e.done, e.drop, e.err, e.busy);
            end
        end
    end

    task automatic drive(input string tag, input logic r, input logic sw, input logic [7:0] d,
                         input logic [3:0] full, input logic [3:0] wr, input logic [7:0] dat,
                         input logic done, input logic drop, input logic err, input logic bsy);
        exp_t e;
        @(negedge clk);
        rst          = r;
        sw_enable_in = sw;
        data_in      = d;
        fifo_full    = full;
        e = '{wr: wr, data: dat, done: done, drop: drop, err: err, busy: bsy};
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic test_reset();
        drive("rst0", 1, 1, 8'h22, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        drive("rst1", 1, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        drive("rst2", 0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        vectors++;
        if ({wr_en, fifo_data, busy, pkt_done, pkt_drop, err_len} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 0000",
                     {wr_en, fifo_data, busy, pkt_done, pkt_drop, err_len});
        end
    endtask

    task automatic test_unicast();
        port_addr = {8'h44, 8'h33, 8'h22, 8'h11};
        drive("uni_da",  0, 1, 8'h22, 4'h0, 4'b0010, 8'h22, 0, 0, 0, 1);
        drive("uni_sa",  0, 1, 8'h05, 4'h0, 4'b0010, 8'h05, 0, 0, 0, 1);
        drive("uni_len", 0, 1, 8'h02, 4'h0, 4'b0010, 8'h02, 0, 0, 0, 1);
        drive("uni_p0",  0, 1, 8'hAA, 4'h0, 4'b0010, 8'hAA, 0, 0, 0, 1);
        drive("uni_p1",  0, 1, 8'hBB, 4'h0, 4'b0010, 8'hBB, 1, 0, 0, 1);
        drive("uni_low", 0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic test_multicast_len0();
        port_addr = {8'h44, 8'h22, 8'h22, 8'h11};
        drive("mc_da",  0, 1, 8'h22, 4'h0, 4'b0110, 8'h22, 0, 0, 0, 1);
        drive("mc_sa",  0, 1, 8'h07, 4'h0, 4'b0110, 8'h07, 0, 0, 0, 1);
        drive("mc_len", 0, 1, 8'h00, 4'h0, 4'b0110, 8'h00, 1, 0, 0, 1);
        drive("mc_low", 0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic test_drop();
        port_addr = {8'h44, 8'h33, 8'h22, 8'h11};
        drive("nomatch_da", 0, 1, 8'h99, 4'h0, 4'h0, 8'h00, 0, 1, 0, 0);
        drive("nomatch_b1", 0, 1, 8'h01, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        drive("nomatch_b2", 0, 1, 8'h02, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        drive("nomatch_lo", 0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        drive("full_da",    0, 1, 8'h11, 4'b0001, 4'h0, 8'h00, 0, 1, 0, 0);
        drive("full_b1",    0, 1, 8'h05, 4'b0001, 4'h0, 8'h00, 0, 0, 0, 0);
        drive("full_lo",    0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        drive("after_drop", 0, 1, 8'h11, 4'h0, 4'b0001, 8'h11, 0, 0, 0, 1);
        drive("after_lo",   0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 1, 0);
    endtask

    task automatic test_len_err();
        drive("err_da",  0, 1, 8'h33, 4'h0, 4'b0100, 8'h33, 0, 0, 0, 1);
        drive("err_sa",  0, 1, 8'h01, 4'h0, 4'b0100, 8'h01, 0, 0, 0, 1);
        drive("err_len", 0, 1, 8'h05, 4'h0, 4'b0100, 8'h05, 0, 0, 0, 1);
        drive("err_p0",  0, 1, 8'hC0, 4'h0, 4'b0100, 8'hC0, 0, 0, 0, 1);
        drive("err_p1",  0, 1, 8'hC1, 4'h0, 4'b0100, 8'hC1, 0, 0, 0, 1);
        drive("err_low", 0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 1, 0);
        @(posedge clk);
        #3;
        vectors++;
        if (busy !== 1'b0 || pkt_done !== 1'b0) begin
            miscompares++;
            $display("FAIL len_err_idle: got busy=%b done=%b required busy=0 done=0", busy, pkt_done);
        end
        drive("err_gap", 0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic test_extra_bytes();
        drive("ext_da",  0, 1, 8'h11, 4'h0, 4'b0001, 8'h11, 0, 0, 0, 1);
        drive("ext_sa",  0, 1, 8'h02, 4'h0, 4'b0001, 8'h02, 0, 0, 0, 1);
        drive("ext_len", 0, 1, 8'h01, 4'h0, 4'b0001, 8'h01, 0, 0, 0, 1);
        drive("ext_p0",  0, 1, 8'h5A, 4'h0, 4'b0001, 8'h5A, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive("ext_ign", 0, 1, 8'hE0 + 8'(i), 4'h0, 4'h0, 8'h00, 0, 0, 0, 1);
        end
        drive("ext_low", 0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic test_full_mid();
        port_addr = {8'h44, 8'h22, 8'h22, 8'h11};
        drive("fm_da",  0, 1, 8'h22, 4'h0,    4'b0110, 8'h22, 0, 0, 0, 1);
        drive("fm_sa",  0, 1, 8'h09, 4'b0100, 4'b0010, 8'h09, 0, 0, 0, 1);
        drive("fm_len", 0, 1, 8'h01, 4'b1001, 4'b0110, 8'h01, 0, 0, 0, 1);
        drive("fm_p0",  0, 1, 8'h77, 4'b0010, 4'b0100, 8'h77, 1, 0, 0, 1);
        drive("fm_low", 0, 0, 8'h00, 4'h0,    4'h0,    8'h00, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        port_addr = {8'h44, 8'h33, 8'h22, 8'h11};
        drive("rm_da",   0, 1, 8'h44, 4'h0, 4'b1000, 8'h44, 0, 0, 0, 1);
        drive("rm_sa",   0, 1, 8'h03, 4'h0, 4'b1000, 8'h03, 0, 0, 0, 1);
        drive("rm_len",  0, 1, 8'h03, 4'h0, 4'b1000, 8'h03, 0, 0, 0, 1);
        drive("rm_p0",   0, 1, 8'hD0, 4'h0, 4'b1000, 8'hD0, 0, 0, 0, 1);
        drive("rm_rst",  1, 1, 8'hD1, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        drive("rm_newda",0, 1, 8'h22, 4'h0, 4'b0010, 8'h22, 0, 0, 0, 1);
        drive("rm_low",  0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 1, 0);
        drive("b2b_da",  0, 1, 8'h11, 4'h0, 4'b0001, 8'h11, 0, 0, 0, 1);
        drive("b2b_sa",  0, 1, 8'h04, 4'h0, 4'b0001, 8'h04, 0, 0, 0, 1);
        drive("b2b_len", 0, 1, 8'h00, 4'h0, 4'b0001, 8'h00, 1, 0, 0, 1);
        drive("b2b_low", 0, 0, 8'h00, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_multicast_len0();
        test_drop();
        test_len_err();
        test_extra_bytes();
        test_full_mid();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #4;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
